fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the FIFO write port.
REQ-002 Parameter DW, default 8: data word width.
REQ-003 Parameter MAX_BURST, default 4: maximum words written per grant (range 1..15).
REQ-004 clk  input  1: single write-domain clock; all logic on the rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 req  input  NREQ: per-requester write request; bit i is held high while requester i has a word ready.
REQ-007 req_data  input  NREQ*DW: requester i data in bits [i*DW +: DW].
REQ-008 full  input  1: FIFO full flag from the write-side pointer logic.
REQ-009 gnt  output  NREQ: registered one-hot grant; all zero when idle.
REQ-010 ack  output  NREQ: combinational per-requester word-accepted strobe.
REQ-011 wr  output  1: combinational FIFO write strobe.
REQ-012 wdata  output  DW: FIFO write data.
REQ-013 busy  output  1: registered; high while in state BURST.

Function
REQ-014 The block SHALL implement two states: IDLE and BURST.
REQ-015 IDLE: if req is nonzero, select the first requesting index after last_gnt in circular order, set that gnt bit, clear burst_cnt, and enter BURST on the next edge. If req is zero, remain in IDLE.
REQ-016 IDLE: gnt, ack and wr SHALL all be 0; no word is written in the selection cycle.
REQ-017 BURST, granted index g: xfer = req[g] & ~full; ack[g] = xfer, all other ack bits 0, and wr = xfer.
REQ-018 wdata SHALL equal the req_data slice of the granted index while in BURST, and all zeros in IDLE.
REQ-019 wr SHALL never be 1 in a cycle where full is 1.
REQ-020 Each xfer cycle SHALL increment the 4-bit burst_cnt by 1; while full is 1, burst_cnt, gnt and state SHALL hold.
REQ-021 BURST SHALL return to IDLE, clearing gnt at that edge, when either:
  - xfer occurs with burst_cnt == MAX_BURST-1, or
  - req[g] is 0.
REQ-022 last_gnt SHALL be updated to the selected index at the IDLE->BURST edge.
REQ-023 A requester that drops req and re-raises it SHALL lose its grant and re-arbitrate from IDLE.
REQ-024 full rising mid-burst SHALL stall without losing or duplicating a word. The stalled word is written on the first cycle full is low, provided req[g] is still high.
REQ-025 Minimum spacing between consecutive bursts is one IDLE cycle; worst-case grant latency from req rising is NREQ*(MAX_BURST+1) cycles, excluding full stalls.
REQ-026 Arbitration SHALL be starvation-free: each continuously requesting index is granted within NREQ-1 other bursts.

Reset
REQ-027 When rst_n is low, the block SHALL enter IDLE, and gnt, busy and burst_cnt SHALL be 0.
REQ-028 When rst_n is low, last_gnt SHALL be NREQ-1, so that requester 0 has first priority after reset.
REQ-029 When rst_n is low, ack, wr and wdata SHALL be 0 combinationally.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately; words already acked stay written and no partial word is issued.

Verification
REQ-031 Single requester: req=4'b0001, full=0, MAX_BURST=4 -> gnt=0001 one cycle after req; wr high exactly 4 consecutive cycles with req_data[7:0]; then gnt=0000 for one cycle; then regrant.
REQ-032 All requesting: req=4'b1111, no full -> grant order 0,1,2,3,0; 4 words each; never two gnt bits set.
REQ-033 Full stall: full=1 for 3 cycles after the 2nd word of a burst -> wr=0 and burst_cnt held during the stall; words 3-4 follow; total wr count is 4; wr&full never true.
REQ-034 Early release: requester 2 drops req after 1 word -> gnt clears the following edge; the next grant goes to requester 3 if it is requesting.
REQ-035 Reset mid-burst: rst_n low after 2 words -> gnt, busy and wr are 0 immediately; after release with req=4'b0110, the first grant is 0010.
REQ-036 Random stress: random req/full for 10k cycles -> scoreboard confirms each wr carries the granted requester's data, ack count per requester equals its words consumed, and no starvation beyond REQ-026.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that lets NREQ requesters share one FIFO write port.
// A requester wins a grant and then writes up to MAX_BURST words. The grant
// ends early if the requester drops its request. The FIFO full flag stalls
// the burst without losing a word.
//
// Ports:
//   clk      - write-domain clock; all logic runs on the rising edge
//   rst_n    - asynchronous active-low reset
//   req      - per-requester "word ready" request
//   req_data - requester i data in bits [i*DW +: DW]
//   full     - FIFO full flag
//   gnt      - registered one-hot grant; zero while idle
//   ack      - combinational per-requester word-accepted strobe
//   wr       - combinational FIFO write strobe
//   wdata    - FIFO write data; the granted slice, zero while idle
//   busy     - registered; high while a burst is in progress
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               full,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic               wr,
    output logic [DW-1:0]      wdata,
    output logic               busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   last_gnt;
    logic [IW-1:0]   sel_idx;
    logic            sel_valid;
    logic [3:0]      burst_cnt;
    logic            in_burst;
    logic            xfer;
    int              cand;

    // Circular search starting just after the last winner. The winner is
    // the first requester found; last_gnt itself is checked last, which
    // keeps the scheme starvation-free.
    always_comb begin
        sel_idx   = last_gnt;
        sel_valid = 1'b0;
        cand      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(last_gnt) + i) % NREQ;
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(cand);
            end
        end
    end

    // The outputs are gated by rst_n so that they fall at once when reset
    // is asserted. This aborts a burst mid-word without issuing a partial
    // write. Gating by full ensures that wr and full are never both high.
    assign in_burst = rst_n && (state == BURST);
    assign xfer     = in_burst && req[gnt_idx] && !full;
    assign wr       = xfer;
    assign ack      = xfer ? (NREQ'(1) << gnt_idx) : '0;
    assign wdata    = in_burst ? req_data[gnt_idx*DW +: DW] : '0;

    // Arbitration FSM. The grant is chosen in IDLE and becomes visible on
    // the next edge, so no word is written in the selection cycle. A stall
    // caused by full holds every register, so the stalled word is written
    // on the first cycle in which full is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            burst_cnt <= '0;
            gnt_idx   <= '0;
            last_gnt  <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state     <= BURST;
                        gnt       <= NREQ'(1) << sel_idx;
                        gnt_idx   <= sel_idx;
                        last_gnt  <= sel_idx;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                BURST: begin
                    if (!req[gnt_idx]) begin
                        // The requester withdrew; it must re-arbitrate.
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else if (!full) begin
                        burst_cnt <= burst_cnt + 4'd1;
                        if (burst_cnt == 4'(MAX_BURST - 1)) begin
                            state <= IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter with NREQ=4, DW=8 and MAX_BURST=4.
// Directed cycle-by-cycle vectors cover reset, single bursts, round-robin
// order, full stalls, early release and reset mid-burst. These are followed
// by a random run with a small scoreboard.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               full;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               wr;
    logic [DW-1:0]      wdata;
    logic               busy;

    int check_count;
    int error_count;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .gnt      (gnt),
        .ack      (ack),
        .wr       (wr),
        .wdata    (wdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed per-requester data pattern: 10, 21, 32, 43.
    function automatic logic [DW-1:0] slot_data(input int i);
        return 8'(8'h10 + 8'h11 * i);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [NREQ-1:0] req_v, input logic full_v);
        req  = req_v;
        full = full_v;
    endtask

    // Checks the outputs of the current cycle and then advances one clock.
    task automatic expect_cycle(input string tag, input logic [NREQ-1:0] e_gnt,
                                input logic [NREQ-1:0] e_ack, input logic e_wr,
                                input logic [DW-1:0] e_wdata, input logic e_busy);
        #1;
        check_output({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
        check_output({tag, ".ack"},   32'(ack),   32'(e_ack));
        check_output({tag, ".wr"},    32'(wr),    32'(e_wr));
        check_output({tag, ".wdata"}, 32'(wdata), 32'(e_wdata));
        check_output({tag, ".busy"},  32'(busy),  32'(e_busy));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply_stimulus('0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard state for the random run.
    logic [NREQ-1:0] prev_gnt;
    logic [NREQ-1:0] prev_req;
    int wait_bursts [NREQ];
    int ack_cnt [NREQ];
    int used_cnt [NREQ];
    int max_wait;
    int idx;

    initial begin
        check_count = 0;
        error_count = 0;
        rst_n    = 1'b0;
        req      = '0;
        full     = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = slot_data(i);

        // Reset values, including with requests pending.
        #2;
        apply_stimulus(4'b1111, 1'b0);
        #1;
        check_output("rst.gnt",   32'(gnt),   0);
        check_output("rst.busy",  32'(busy),  0);
        check_output("rst.ack",   32'(ack),   0);
        check_output("rst.wr",    32'(wr),    0);
        check_output("rst.wdata", 32'(wdata), 0);
        do_reset();

        // Single requester: 4 words, one idle gap, regrant, release.
        $display("[TB] single requester");
        apply_stimulus(4'b0001, 1'b0);
        expect_cycle("single.sel", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        for (int w = 0; w < MAX_BURST; w++)
            expect_cycle("single.word", 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
        expect_cycle("single.gap", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        expect_cycle("single.regrant", 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
        apply_stimulus(4'b0000, 1'b0);
        expect_cycle("single.drop", 4'b0001, 4'b0000, 1'b0, 8'h10, 1'b1);
        expect_cycle("single.idle", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);

        // All requesting: order 0,1,2,3 and then back to 0.
        $display("[TB] round robin");
        do_reset();
        apply_stimulus(4'b1111, 1'b0);
        expect_cycle("rr.sel", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k <= NREQ; k++) begin
            for (int w = 0; w < ((k == NREQ) ? 1 : MAX_BURST); w++)
                expect_cycle("rr.word", 4'(1 << (k % NREQ)), 4'(1 << (k % NREQ)), 1'b1,
                             slot_data(k % NREQ), 1'b1);
            if (k < NREQ)
                expect_cycle("rr.gap", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        end

        // Full stall after the second word; the burst still totals 4 words.
        $display("[TB] full stall");
        do_reset();
        apply_stimulus(4'b0001, 1'b0);
        expect_cycle("stall.sel", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        expect_cycle("stall.w1", 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
        expect_cycle("stall.w2", 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
        apply_stimulus(4'b0001, 1'b1);
        for (int s = 0; s < 3; s++)
            expect_cycle("stall.hold", 4'b0001, 4'b0000, 1'b0, 8'h10, 1'b1);
        apply_stimulus(4'b0001, 1'b0);
        expect_cycle("stall.w3", 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
        expect_cycle("stall.w4", 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
        expect_cycle("stall.end", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);

        // Early release by requester 2; requester 3 is next.
        $display("[TB] early release");
        do_reset();
        apply_stimulus(4'b0100, 1'b0);
        expect_cycle("early.sel", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        expect_cycle("early.w1", 4'b0100, 4'b0100, 1'b1, 8'h32, 1'b1);
        apply_stimulus(4'b1000, 1'b0);
        expect_cycle("early.drop", 4'b0100, 4'b0000, 1'b0, 8'h32, 1'b1);
        expect_cycle("early.idle", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        expect_cycle("early.next", 4'b1000, 4'b1000, 1'b1, 8'h43, 1'b1);

        // Reset mid-burst after 2 words.
        $display("[TB] reset mid-burst");
        do_reset();
        apply_stimulus(4'b0001, 1'b0);
        expect_cycle("mrst.sel", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        expect_cycle("mrst.w1", 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
        expect_cycle("mrst.w2", 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("mrst.now.gnt",   32'(gnt),   0);
        check_output("mrst.now.busy",  32'(busy),  0);
        check_output("mrst.now.wr",    32'(wr),    0);
        check_output("mrst.now.ack",   32'(ack),   0);
        check_output("mrst.now.wdata", 32'(wdata), 0);
        @(posedge clk);
        #1;
        apply_stimulus(4'b0110, 1'b0);
        rst_n = 1'b1;
        expect_cycle("mrst.sel2", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        expect_cycle("mrst.grant", 4'b0010, 4'b0010, 1'b1, 8'h21, 1'b1);

        // Random stress with a scoreboard.
        $display("[TB] random stress");
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            wait_bursts[i] = 0;
            ack_cnt[i]     = 0;
            used_cnt[i]    = 0;
        end
        max_wait = 0;
        prev_gnt = '0;
        prev_req = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
                req_data[i*DW +: DW] = 8'($urandom);
            end
            full = ($urandom_range(3) == 0);
            #1;
            check_output("rnd.wr_full", 32'(wr & full), 0);
            check_output("rnd.onehot0", 32'($countones(gnt) <= 1), 1);
            check_output("rnd.busy", 32'(busy), 32'(gnt != '0));
            if (wr) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = i;
                check_output("rnd.wdata", 32'(wdata), 32'(req_data[idx*DW +: DW]));
                check_output("rnd.ack", 32'(ack), 32'(gnt));
            end else begin
                check_output("rnd.ack_idle", 32'(ack), 0);
            end
            for (int i = 0; i < NREQ; i++) begin
                ack_cnt[i] += int'(ack[i]);
                if (gnt[i] && req[i] && !full) used_cnt[i]++;
                if (!req[i]) wait_bursts[i] = 0;
            end
            if (prev_gnt == '0 && gnt != '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt[i]) wait_bursts[i] = 0;
                    else if (req[i] && prev_req[i]) begin
                        wait_bursts[i]++;
                        if (wait_bursts[i] > max_wait) max_wait = wait_bursts[i];
                    end
                end
            end
            prev_gnt = gnt;
            prev_req = req;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < NREQ; i++)
            check_output("rnd.ack_count", 32'(ack_cnt[i]), 32'(used_cnt[i]));
        check_output("rnd.starvation", 32'(max_wait <= NREQ - 1), 1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
